// File: rtl/regfile_pkg.sv
// Shared defaults and the byte-merge helper for the multi-port register file.
// The merge function works on a wide word; callers zero-extend and truncate.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int BYTES      = DEF_DATA_W / 8;
    localparam int MAX_W      = 256;

    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]   oldWord,
        input logic [MAX_W-1:0]   newWord,
        input logic [MAX_W/8-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = oldWord;
        for (int b = 0; b < MAX_W / 8; b++) begin
            if (be[b]) res[8*b +: 8] = newWord[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-entry override, write bypass and output flops.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                re,
    input  logic [ADDR_W-1:0]   rdAddr,
    input  logic [DATA_W-1:0]   memWord,
    input  logic                write,
    input  logic [ADDR_W-1:0]   wrAddr,
    input  logic [DATA_W-1:0]   wrData,
    input  logic [DATA_W/8-1:0] wrBE,
    output logic [DATA_W-1:0]   rdData,
    output logic                rdValid
);

    logic [DATA_W-1:0] nextWord;

    // Zero entry wins over bypass so a dropped write can never leak through.
    always_comb begin
        nextWord = memWord;
        if (ZERO_REG != 0 && rdAddr == '0)
            nextWord = '0;
        else if (BYPASS != 0 && write && rdAddr == wrAddr)
            nextWord = DATA_W'(merge_bytes(MAX_W'(memWord), MAX_W'(wrData), (MAX_W/8)'(wrBE)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= re;
            if (re) rdData <= nextWord;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: storage array and byte-enabled write port,
// with NUM_RD independent registered read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          wrAddr,
    input  logic [DATA_W-1:0]          wrData,
    input  logic [DATA_W/8-1:0]        wrBE,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    output logic [NUM_RD-1:0]          rdValid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wrEn;

    assign wrEn = write && !(ZERO_REG != 0 && wrAddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wrEn) begin
            mem[wrAddr] <= DATA_W'(merge_bytes(MAX_W'(mem[wrAddr]), MAX_W'(wrData), (MAX_W/8)'(wrBE)));
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gRd
        logic [ADDR_W-1:0] addr;
        assign addr = rdAddr[p*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) uPort (
            .clk    (clk),
            .rst    (rst),
            .re     (re[p]),
            .rdAddr (addr),
            .memWord(mem[addr]),
            .write  (write),
            .wrAddr (wrAddr),
            .wrData (wrData),
            .wrBE   (wrBE),
            .rdData (rdData[p*DATA_W +: DATA_W]),
            .rdValid(rdValid[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default instance plus a ZERO_REG=0/BYPASS=0 instance on shared inputs.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [3:0]  wrBE = '0;
    logic [1:0]  re = '0;
    logic [9:0]  rdAddr = '0;
    logic [63:0] rdData, rdDataB;
    logic [1:0]  rdValid, rdValidB;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk(clk), .rst(rst), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .wrBE(wrBE), .re(re), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid)
    );

    regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dutB (
        .clk(clk), .rst(rst), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .wrBE(wrBE), .re(re), .rdAddr(rdAddr), .rdData(rdDataB), .rdValid(rdValidB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1'b1; wrAddr = a; wrData = d; wrBE = be;
        tick();
        write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (rdData !== 64'h0 || rdValid !== 2'b00) begin
            errors++;
            $display("FAIL reset_out got %h/%b want 0/00", rdData, rdValid);
        end
        checks++;
        if (rdDataB !== 64'h0 || rdValidB !== 2'b00) begin
            errors++;
            $display("FAIL reset_outB got %h/%b want 0/00", rdDataB, rdValidB);
        end
        rst = 1'b0;
        tick();
        for (int a = 0; a < 32; a++) begin
            rdAddr = {5'(a), 5'(a)};
            re = 2'b11;
            tick();
            checks++;
            if (rdData !== 64'h0 || rdValid !== 2'b11) begin
                errors++;
                $display("FAIL reset_read addr %0d got %h/%b want 0/11", a, rdData, rdValid);
            end
        end
        re = 2'b00;
        tick();
    endtask

    task automatic test_sweep();
        logic [31:0] expA, expB;
        logic        reA, reB;
        int          km1;
        expA = '0; expB = '0;
        for (int i = 0; i < 32; i++) doWrite(5'(i), 32'(i * 11111), 4'hF);
        for (int k = 0; k < 32; k++) begin
            km1 = (k + 31) % 32;
            reA = !(k == 2 || k == 5);
            reB = !(k == 0 || k == 9);
            rdAddr = {5'(km1), 5'(k)};
            re = {reB, reA};
            tick();
            if (reA) expA = 32'(k * 11111);
            if (reB) expB = 32'(km1 * 11111);
            checks++;
            if (rdData[31:0] !== expA || rdValid[0] !== reA) begin
                errors++;
                $display("FAIL sweep_A k=%0d got %h/%b want %h/%b", k, rdData[31:0], rdValid[0], expA, reA);
            end
            checks++;
            if (rdData[63:32] !== expB || rdValid[1] !== reB) begin
                errors++;
                $display("FAIL sweep_B k=%0d got %h/%b want %h/%b", k, rdData[63:32], rdValid[1], expB, reB);
            end
        end
        re = 2'b00;
    endtask

    task automatic test_byte_enable();
        doWrite(5'd7, 32'hDEADBEEF, 4'hF);
        doWrite(5'd7, 32'h11223344, 4'b0101);
        doWrite(5'd7, 32'h99999999, 4'b0000);
        rdAddr[4:0] = 5'd7;
        re = 2'b01;
        tick();
        re = 2'b00;
        checks++;
        if (rdData[31:0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_enable got %h want DE22BE44", rdData[31:0]);
        end
        checks++;
        if (rdDataB[31:0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_enableB got %h want DE22BE44", rdDataB[31:0]);
        end
    endtask

    task automatic test_bypass();
        doWrite(5'd9, 32'h12345678, 4'hF);
        write = 1'b1; wrAddr = 5'd9; wrData = 32'hCAFEF00D; wrBE = 4'b1100;
        rdAddr[4:0] = 5'd9;
        re = 2'b01;
        tick();
        write = 1'b0;
        re = 2'b00;
        checks++;
        if (rdData[31:0] !== 32'hCAFE5678) begin
            errors++;
            $display("FAIL bypass_on got %h want CAFE5678", rdData[31:0]);
        end
        checks++;
        if (rdDataB[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_off got %h want 12345678", rdDataB[31:0]);
        end
        re = 2'b01;
        tick();
        re = 2'b00;
        checks++;
        if (rdData[31:0] !== 32'hCAFE5678 || rdDataB[31:0] !== 32'hCAFE5678) begin
            errors++;
            $display("FAIL bypass_commit got %h/%h want CAFE5678", rdData[31:0], rdDataB[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        doWrite(5'd0, 32'hFFFFFFFF, 4'hF);
        rdAddr[9:5] = 5'd0;
        re = 2'b10;
        tick();
        checks++;
        if (rdData[63:32] !== 32'h0 || rdValid !== 2'b10) begin
            errors++;
            $display("FAIL zero_read got %h/%b want 0/10", rdData[63:32], rdValid);
        end
        checks++;
        if (rdDataB[63:32] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL zero_readB got %h want FFFFFFFF", rdDataB[63:32]);
        end
        // write to entry 0 while both ports read it
        write = 1'b1; wrAddr = 5'd0; wrData = 32'h13572468; wrBE = 4'hF;
        rdAddr = 10'd0;
        re = 2'b11;
        tick();
        write = 1'b0;
        checks++;
        if (rdData !== 64'h0) begin
            errors++;
            $display("FAIL zero_nobypass got %h want 0", rdData);
        end
        checks++;
        if (rdDataB !== 64'hFFFFFFFF_FFFFFFFF) begin
            errors++;
            $display("FAIL zero_sameaddrB got %h want FFFFFFFFFFFFFFFF", rdDataB);
        end
        tick();
        re = 2'b00;
        checks++;
        if (rdDataB !== 64'h13572468_13572468 || rdData !== 64'h0) begin
            errors++;
            $display("FAIL zero_after got %h/%h want 0/1357246813572468", rdData, rdDataB);
        end
    endtask

    task automatic test_async_reset();
        doWrite(5'd3, 32'hA5A5A5A5, 4'hF);
        rdAddr[4:0] = 5'd3;
        re = 2'b01;
        tick();
        re = 2'b00;
        checks++;
        if (rdData[31:0] !== 32'hA5A5A5A5 || rdValid[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got %h/%b want A5A5A5A5/1", rdData[31:0], rdValid[0]);
        end
        #2;
        write = 1'b1; wrAddr = 5'd5; wrData = 32'h77777777; wrBE = 4'hF;
        rst = 1'b1;
        #1;
        checks++;
        if (rdData !== 64'h0 || rdValid !== 2'b00 || rdDataB !== 64'h0 || rdValidB !== 2'b00) begin
            errors++;
            $display("FAIL async_clear got %h/%b %h/%b want 0", rdData, rdValid, rdDataB, rdValidB);
        end
        tick();
        write = 1'b0;
        tick();
        rst = 1'b0;
        rdAddr = {5'd5, 5'd3};
        re = 2'b11;
        tick();
        re = 2'b00;
        checks++;
        if (rdData !== 64'h0 || rdValid !== 2'b11 || rdDataB !== 64'h0) begin
            errors++;
            $display("FAIL async_after got %h/%b %h want 0/11", rdData, rdValid, rdDataB);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_byte_enable();
        test_bypass();
        test_zero_reg();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file. Successor to the fixed 32x32, two-read-port register file.
- Adds:
  - configurable width, depth and read-port count
  - byte-enabled writes
  - registered reads with per-port read enable and a valid flag
  - write-to-read bypass
  - optional hardwired-zero entry 0
  - asynchronous clear of all storage
- Sits between the datapath operand-fetch stage and writeback.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..8).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage.
- BYPASS, 1, 1 = a same-cycle write to the addressed entry is forwarded to the read result; 0 = the read returns the pre-write contents.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- write  in  1  write enable.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- wrBE  in  DATA_W/8  byte enables; bit b qualifies wrData[8b+7:8b].
- re  in  NUM_RD  per-port read enable.
- rdAddr  in  NUM_RD*ADDR_W  flattened read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rdData  out  NUM_RD*DATA_W  flattened registered read data.
- rdValid  out  NUM_RD  per-port flag: rdData for that port was updated on the last edge.

Behaviour:
- Reset, asynchronous on rst high:
  - all storage entries are 0
  - rdData = 0 and rdValid = 0 on all ports
  - state holds while rst is high; write and re are ignored
  - deassertion takes effect at the next rising clk
- Write, at the rising edge with write=1:
  - mem[wrAddr] byte b <= wrData byte b for each wrBE[b]=1; bytes with wrBE[b]=0 are unchanged.
  - write=1 with wrBE all 0 is a no-op.
  - ZERO_REG=1 and wrAddr=0: write is dropped.
- Read latency is 1 cycle. At the rising edge with re[p]=1:
  - rdData[p] <= value of mem[rdAddr[p]] as seen at that edge.
  - rdValid[p] <= 1.
- re[p]=0: rdData[p] holds its previous value; rdValid[p] <= 0.
- Bypass:
  - BYPASS=1, write=1, re[p]=1 and rdAddr[p]==wrAddr in the same cycle: rdData[p] receives the merged value, i.e. new bytes where wrBE=1 and old bytes elsewhere.
  - BYPASS=0: rdData[p] receives the old value; the write still commits.
- ZERO_REG=1 with rdAddr[p]=0 and re[p]=1: rdData[p] <= 0, never bypassed.
- Multiple ports:
  - may read the same address in the same cycle; each gets an identical result.
  - ports are fully independent otherwise.
- Reset mid-operation: a write in the same cycle rst asserts is lost; outputs clear immediately, without waiting for clk.
- Address range is full 2**ADDR_W; no out-of-range case exists.
- There is no state machine beyond the storage array and the per-port output registers.

Decomposition:
- Package regfile_pkg:
  - default DATA_W, ADDR_W, NUM_RD
  - BYTES = DATA_W/8
  - a function merge_bytes(old, new, be) returning the byte-merged word, shared by the write path and the bypass path
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate. It contains:
  - the address compare against the write port
  - the ZERO_REG override
  - the bypass mux
  - the rdData/rdValid output registers with asynchronous rst
- The top holds the storage array and the write logic.

Test Plan:
- Reset check: rst=1 for 3 cycles, then release → rdData=0 and rdValid=0 on all ports; reading every address with re=1 returns 0.
- Full write/read sweep: write i*11111 to addr i=0..31 with wrBE=4'hF, then read with port A=k and port B=k-1 → A returns k*11111 (addr 0 returns 0 with ZERO_REG=1) and B returns (k-1)*11111, one cycle after each request; dropping re on A at k=2,5 and on B at k=0,9 → that port holds its previous data with rdValid=0.
- Byte enable: write 32'hDEADBEEF full to addr 7, then write 32'h11223344 with wrBE=4'b0101 → read addr 7 = 32'hDE22BE44.
- Bypass: same cycle write=1, wrAddr=9, wrData=32'hCAFEF00D, wrBE=4'b1100, old mem[9]=32'h12345678, re[0]=1, rdAddr0=9 → next cycle rdData0=32'hCAFE5678; with BYPASS=0 → 32'h12345678, and a following read → 32'hCAFE5678.
- Zero register: write 32'hFFFFFFFF to addr 0 → reads of addr 0 return 0 (ZERO_REG=1); with ZERO_REG=0 → 32'hFFFFFFFF.
- Async reset mid-run: assert rst between clock edges after writing 32'hA5A5A5A5 to addr 3 → rdData clears before the next edge; after release, read addr 3 = 0.
